// File: rtl/uart_rx_parity.sv
// 8E1 UART receiver: 2-FF synchronized line, mid-bit sampling,
// one-cycle valid strobe with parity and framing error flags.
module uart_rx_parity #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [CW-1:0] r_clk_ctr;
    logic [CW-1:0] w_ctr_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_par_acc;
    logic          w_par_nxt;
    logic          r_par_bad;
    logic          w_parbad_nxt;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_perr;
    logic          w_perr_nxt;
    logic          r_ferr;
    logic          w_ferr_nxt;
    logic          w_rx_s;
    logic          w_fall;
    logic          w_full;

    assign w_rx_s = r_sync2;
    // Edge needs a high before the low, so a held-low line after a
    // framing error cannot re-trigger until it has returned to idle.
    assign w_fall = r_prev & ~w_rx_s;
    assign w_full = (r_clk_ctr == C_FULL);

    always_comb begin
        w_state_nxt  = r_state;
        w_ctr_nxt    = r_clk_ctr + CW'(1);
        w_idx_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par_acc;
        w_parbad_nxt = r_par_bad;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_perr_nxt   = r_perr;
        w_ferr_nxt   = r_ferr;
        unique case (r_state)
            RX_IDLE: begin
                w_ctr_nxt = '0;
                w_idx_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = RX_START;
                    w_par_nxt   = 1'b0;
                end
            end
            RX_START: begin
                if (r_clk_ctr == C_HALF) begin
                    w_ctr_nxt   = '0;
                    w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_full) begin
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    w_par_nxt = r_par_acc ^ w_rx_s;
                    w_ctr_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = RX_PARITY;
                    end else begin
                        w_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_full) begin
                    w_parbad_nxt = r_par_acc ^ w_rx_s;
                    w_ctr_nxt    = '0;
                    w_state_nxt  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_full) begin
                    w_data_nxt  = r_shift;
                    w_valid_nxt = 1'b1;
                    w_perr_nxt  = r_par_bad;
                    w_ferr_nxt  = ~w_rx_s;
                    w_ctr_nxt   = '0;
                    w_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_ctr_nxt   = '0;
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RX_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_clk_ctr <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_par_bad <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_clk_ctr <= w_ctr_nxt;
            r_bit_idx <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par_acc <= w_par_nxt;
            r_par_bad <= w_parbad_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_perr    <= w_perr_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Bench for uart_rx_parity: bit-level line driver plus a
// scoreboard of expected bytes checked on each valid strobe.
module tb_uart_rx_parity;

    localparam int CLKS = 434;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vtimes[$];
    int   tests  = 0;
    int   fails  = 0;
    int   nvalid = 0;
    int   cyc    = 0;
    logic prev_v = 1'b0;

    uart_rx_parity dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid) begin
            nvalid++;
            vtimes.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe data=%h pe=%b fe=%b required none",
                         data_out, parity_err, frame_err);
            end else begin
                e = exp_q.pop_front();
                if ({data_out, parity_err, frame_err} !== {e.d, e.pe, e.fe}) begin
                    fails++;
                    $display("FAIL rx_byte got %h/%b/%b required %h/%b/%b",
                             data_out, parity_err, frame_err, e.d, e.pe, e.fe);
                end
            end
            if (prev_v) begin
                tests++;
                fails++;
                $display("FAIL valid_width got 2+ cycles required 1");
            end
        end
        prev_v = data_valid;
    end

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        serial_in = 1'b1;
        repeat (nbits * CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        exp_t x;
        x.d  = d;
        x.pe = (^d) ^ pb;
        x.fe = ~sb;
        exp_q.push_back(x);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
            fails++;
            $display("FAIL reset_vals got %h/%b/%b/%b/%b required 00/0/0/0/0",
                     data_out, data_valid, parity_err, frame_err, busy);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        int t0;
        vtimes.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL basic_drain got %0d pending required 0", exp_q.size());
        end
        tests++;
        if (vtimes.size() != 1) begin
            fails++;
            $display("FAIL basic_count got %0d strobes required 1", vtimes.size());
        end else if (vtimes[0] - t0 < 4557 || vtimes[0] - t0 > 4563) begin
            fails++;
            $display("FAIL basic_latency got %0d required 4560+-3", vtimes[0] - t0);
        end
    endtask

    task automatic test_parity;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(1);
        tests++;
        if (parity_err !== 1'b1) begin
            fails++;
            $display("FAIL parity_held got %b required 1", parity_err);
        end
        send_frame(8'h07, 1'b1, 1'b1);
        idle(1);
        tests++;
        if (exp_q.size() != 0 || parity_err !== 1'b0) begin
            fails++;
            $display("FAIL parity_fix got pend=%0d pe=%b required 0/0",
                     exp_q.size(), parity_err);
        end
    endtask

    task automatic test_frame;
        int n0;
        send_frame(8'h3C, 1'b0, 1'b0);
        n0 = nvalid;
        repeat (20 * CLKS) @(negedge clk);
        tests++;
        if (nvalid != n0 || busy !== 1'b0 || frame_err !== 1'b1) begin
            fails++;
            $display("FAIL break_hold got dn=%0d busy=%b fe=%b required 0/0/1",
                     nvalid - n0, busy, frame_err);
        end
        idle(2);
        tests++;
        if (nvalid != n0) begin
            fails++;
            $display("FAIL break_release got %0d strobes required 0", nvalid - n0);
        end
        send_frame(8'h11, 1'b0, 1'b1);
        idle(1);
        tests++;
        if (exp_q.size() != 0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_recover got pend=%0d fe=%b required 0/0",
                     exp_q.size(), frame_err);
        end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = nvalid;
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL glitch_busy got %b required 1", busy);
        end
        repeat (50) @(negedge clk);
        serial_in = 1'b1;
        repeat (CLKS / 2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || nvalid != n0) begin
            fails++;
            $display("FAIL glitch_reject got busy=%b dn=%0d required 0/0",
                     busy, nvalid - n0);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        vtimes.delete();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(2);
        tests++;
        if (vtimes.size() != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_count got %0d strobes pend=%0d required 2/0",
                     vtimes.size(), exp_q.size());
        end else if (vtimes[1] - vtimes[0] < 11 * CLKS - 1 ||
                     vtimes[1] - vtimes[0] > 11 * CLKS + 1) begin
            fails++;
            $display("FAIL b2b_gap got %0d required %0d",
                     vtimes[1] - vtimes[0], 11 * CLKS);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        logic [7:0] d;
        d = 8'h5A;
        n0 = nvalid;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        serial_in = d[4];
        repeat (200) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
            fails++;
            $display("FAIL midreset_vals got %h/%b/%b/%b/%b required 00/0/0/0/0",
                     data_out, data_valid, parity_err, frame_err, busy);
        end
        rst = 1'b1;
        idle(2);
        tests++;
        if (nvalid != n0) begin
            fails++;
            $display("FAIL midreset_strobe got %0d required 0", nvalid - n0);
        end
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(2);
        tests++;
        if (exp_q.size() != 0 || nvalid != n0 + 1) begin
            fails++;
            $display("FAIL midreset_next got pend=%0d dn=%0d required 0/1",
                     exp_q.size(), nvalid - n0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
